// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int WIDTH_DEF      = 32;
  localparam int CORE_COUNT_DEF = 4;

  // Ceiling log2, usable in parameter defaults.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v << 1) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first requester strictly after 'last', wrapping.
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int CORE_COUNT = CORE_COUNT_DEF,
  parameter int IDX_W      = clog2(CORE_COUNT)
) (
  input  logic [CORE_COUNT-1:0] req,
  input  logic [IDX_W-1:0]      last,
  output logic                  found,
  output logic [IDX_W-1:0]      idx
);

  // Scan last+1 .. last+CORE_COUNT; the first hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= CORE_COUNT; k++) begin
      if (!found && req[(int'(last) + k) % CORE_COUNT]) begin
        found = 1'b1;
        idx   = IDX_W'((int'(last) + k) % CORE_COUNT);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port among CORE_COUNT cores.
// Optional watchdog: define MEM_ARB_TIMEOUT_EN to abort stuck transactions.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int CORE_COUNT = CORE_COUNT_DEF,
  parameter int IDX_W      = clog2(CORE_COUNT),
  parameter int TIMEOUT    = 255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [CORE_COUNT-1:0]       core_request,
  input  logic [CORE_COUNT-1:0]       core_wren,
  input  logic [CORE_COUNT*WIDTH-1:0] core_address,
  input  logic [CORE_COUNT*WIDTH-1:0] core_writedata,
  output logic [CORE_COUNT-1:0]       core_response,
  output logic [WIDTH-1:0]            core_readdata,
  output logic                        mem_request,
  output logic                        mem_wren,
  output logic [WIDTH-1:0]            mem_address,
  output logic [WIDTH-1:0]            mem_writedata,
  input  logic [WIDTH-1:0]            mem_readdata,
  input  logic                        mem_ack,
  output logic                        grant_valid,
  output logic [IDX_W-1:0]            grant_idx,
  output logic                        timeout_err
);

  if (IDX_W != clog2(CORE_COUNT) || TIMEOUT < 1) begin : g_param_chk
    $error("mem_arbiter: IDX_W must equal clog2(CORE_COUNT) and TIMEOUT >= 1");
  end

  state_e                r_state, w_next;
  logic [IDX_W-1:0]      r_last, w_win, r_grant_idx;
  logic                  w_found, w_tmo;
  logic                  r_mem_req, r_mem_wren, r_grant_valid;
  logic [WIDTH-1:0]      r_mem_addr, r_mem_wdata, r_rdata;
  logic [CORE_COUNT-1:0] r_resp, w_onehot;

  rr_pick #(.CORE_COUNT(CORE_COUNT), .IDX_W(IDX_W)) u_pick (
    .req  (core_request),
    .last (r_last),
    .found(w_found),
    .idx  (w_win)
  );

  assign w_onehot = {{(CORE_COUNT-1){1'b0}}, 1'b1} << r_grant_idx;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = (clog2(TIMEOUT + 1) < 8) ? 8 : clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] r_cnt;
  logic             r_terr;

  // BUSY lasts at most TIMEOUT cycles: the abort fires on the TIMEOUT-th edge.
  assign w_tmo       = (r_cnt == CNT_W'(TIMEOUT - 1));
  assign timeout_err = r_terr;

  // Watchdog counter, zero on BUSY entry; sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_terr <= 1'b0;
    end else if (r_state != BUSY) begin
      r_cnt  <= '0;
    end else if (!mem_ack) begin
      if (w_tmo) r_terr <= 1'b1;
      else       r_cnt  <= r_cnt + 1'b1;
    end
  end
`else
  assign w_tmo       = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_found) w_next = BUSY;
      BUSY:    if (mem_ack || w_tmo) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Grant capture, memory-side registers and core response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last        <= IDX_W'(CORE_COUNT - 1);
      r_mem_req     <= 1'b0;
      r_mem_wren    <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_grant_valid <= 1'b0;
      r_grant_idx   <= '0;
      r_resp        <= '0;
      r_rdata       <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_found) begin
          r_mem_req     <= 1'b1;
          r_mem_wren    <= core_wren[w_win];
          r_mem_addr    <= core_address[int'(w_win)*WIDTH +: WIDTH];
          r_mem_wdata   <= core_writedata[int'(w_win)*WIDTH +: WIDTH];
          r_grant_valid <= 1'b1;
          r_grant_idx   <= w_win;
          r_last        <= w_win;
        end
        BUSY: if (mem_ack) begin
          r_mem_req <= 1'b0;
          r_resp    <= w_onehot;
          if (!r_mem_wren) r_rdata <= mem_readdata;
        end else if (w_tmo) begin
          r_mem_req <= 1'b0;
          r_resp    <= w_onehot;
          r_rdata   <= '0;
        end
        RESP: begin
          r_resp        <= '0;
          r_grant_valid <= 1'b0;
          r_grant_idx   <= '0;
          r_mem_wren    <= 1'b0;
          r_mem_addr    <= '0;
          r_mem_wdata   <= '0;
        end
        default: ;
      endcase
    end
  end

  assign core_response = r_resp;
  assign core_readdata = r_rdata;
  assign mem_request   = r_mem_req;
  assign mem_wren      = r_mem_wren;
  assign mem_address   = r_mem_addr;
  assign mem_writedata = r_mem_wdata;
  assign grant_valid   = r_grant_valid;
  assign grant_idx     = r_grant_idx;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one memory port between CORE_COUNT cores. Each core presents a request/wren/address/writedata bundle and waits for a one-cycle response pulse.
- Grants one core at a time in round-robin order and runs a single transaction against the memory handshake. Read data is returned to the granted core.
- Sits between the core array and the shared RAM controller. Replaces direct core-to-memory wiring.

Parameters:
- WIDTH, 32, data/address width.
- CORE_COUNT, 4, number of requesting cores (2..8).
- IDX_W, 2, width of the core index; must equal clog2(CORE_COUNT).
- TIMEOUT, 255, watchdog limit in cycles (used only with MEM_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- core_request  in  CORE_COUNT  per-core level request; held until that core's response.
- core_wren  in  CORE_COUNT  per-core write enable (1 = write, 0 = read).
- core_address  in  CORE_COUNT*WIDTH  flattened addresses; core i occupies bits [i*WIDTH +: WIDTH].
- core_writedata  in  CORE_COUNT*WIDTH  flattened write data, same packing.
- core_response  out  CORE_COUNT  one-hot, one-cycle completion pulse.
- core_readdata  out  WIDTH  broadcast read data; valid while the granted core's response bit is high.
- mem_request  out  1  memory transaction request.
- mem_wren  out  1  memory write enable.
- mem_address  out  WIDTH  memory address.
- mem_writedata  out  WIDTH  memory write data.
- mem_readdata  in  WIDTH  memory read data; sampled with mem_ack.
- mem_ack  in  1  memory completion; must be high for exactly one cycle while mem_request is high.
- grant_valid  out  1  a transaction is in flight.
- grant_idx  out  IDX_W  index of the granted core.
- timeout_err  out  1  sticky watchdog flag (tied 0 without the macro).

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0. last_grant = CORE_COUNT-1, so core 0 has first priority. Any in-flight transaction is abandoned by dropping mem_request; the memory side must tolerate this.
- States: IDLE, BUSY, RESP.
- IDLE:
  - If any core_request bit is set, select the winner by searching from last_grant+1 upward, wrapping mod CORE_COUNT.
  - Register the winner's address/writedata/wren onto the mem_* outputs, set mem_request=1, grant_valid=1, grant_idx=winner, last_grant=winner; go to BUSY.
  - With no request, stay in IDLE with all outputs 0.
- BUSY:
  - mem_* outputs are held stable.
  - On a rising edge with mem_ack=1: drop mem_request, latch mem_readdata into core_readdata (reads only; writes leave core_readdata unchanged), set core_response[grant_idx]=1; go to RESP.
- RESP:
  - The response pulse is high for exactly this cycle. The core drops its request on this edge.
  - Next edge: clear core_response and grant_valid; go to IDLE. core_readdata holds its value until the next read completes.
- Minimum round trip: request seen at edge 0, mem_request high after edge 0, mem_ack sampled at edge 1, response high between edges 1 and 2, IDLE after edge 2. Next grant is possible at edge 3. The minimum period is therefore 3 cycles per transaction.
- Core requests that change while not granted are ignored until the next IDLE sample.
- Requests appearing during BUSY/RESP wait. A request from the currently granted core at the RESP→IDLE edge is not possible under the core protocol and is not checked.
- Fairness: with all cores requesting continuously, the grant sequence is 0,1,2,3,0,... A core waits at most CORE_COUNT-1 transactions.
- mem_ack outside BUSY is ignored.

Optional Feature:
- MEM_ARB_TIMEOUT_EN defined: an 8+-bit counter is cleared on entry to BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT without mem_ack: drop mem_request, set core_readdata=0, pulse core_response[grant_idx], set timeout_err=1, go to RESP.
  - timeout_err clears only on reset.
- Undefined: no counter. BUSY waits for mem_ack indefinitely. timeout_err is constant 0.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum (IDLE, BUSY, RESP);
  - the default WIDTH/CORE_COUNT constants;
  - a clog2 helper function.
- Sub-module rr_pick (combinational): inputs are req[CORE_COUNT] and last[IDX_W]; outputs are found and idx[IDX_W]. It is instantiated once and unit-tested separately.

Test Plan:
- Reset then single read: core 1 requests address 0x10 and memory acks 1 cycle later with 0xDEADBEEF. Required: mem_address=0x10, mem_wren=0, core_response=4'b0010 for exactly 1 cycle, core_readdata=0xDEADBEEF.
- Write: core 2 has wren=1, address 0x20, data 0x1234. Required: mem_wren=1, mem_writedata=0x1234, response 4'b0100, and core_readdata unchanged from the prior read.
- All four cores requesting continuously with instant ack. Required: grant_idx sequence 0,1,2,3,0 and one transaction every 3 cycles.
- Core 3 requests while core 0 is BUSY with ack delayed 10 cycles. Required: core 3 is granted only after core 0's RESP, and mem_address stays stable for all 10 cycles.
- Reset mid-BUSY: rst_n low asynchronously. Required: mem_request, grant_valid and core_response are 0 immediately, and the next grant goes to core 0.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT=8, never ack. Required: after 8 BUSY cycles a response pulses with readdata 0 and timeout_err=1 stays set.
